instruction_fetch_stage: RTL and testbench

//   IF stage of the pipelined CPU. Owns the program counter and drives the

---
 rtl/instruction_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_stage
//  Purpose  : IF stage. Owns the PC, reads the combinational instruction
//             memory, loads the IF/ID register and handles stall, flush and
//             branch redirection. Bad fetch addresses raise a sticky fault.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_BYTES = 256,
    parameter logic [31:0] NOP_WORD  = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        freeze_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic        if_id_valid_o,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] c_MEM_LIMIT = 32'(MEM_BYTES);

    localparam logic [1:0] c_ST_BOOT  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FAULT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [31:0] w_pc_plus4;
    logic        w_pc_bad;
    logic        w_tgt_misaligned;
    logic        w_bubble;

    // The add wraps at 2^32; a wrapped PC is then caught by the range check.
    assign w_pc_plus4       = pc_q + 32'd4;
    assign w_pc_bad         = (pc_q >= c_MEM_LIMIT) || (pc_q[1:0] != 2'b00);
    assign w_tgt_misaligned = (branch_target_i[1:0] != 2'b00);

    // Next-state selection, following the RUN-state priority order.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        valid_d  = valid_q;
        fault_d  = fault_q;
        count_d  = count_q;
        w_bubble = 1'b0;

        case (state_q)
            c_ST_BOOT: begin
                state_d = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_pc_bad) begin
                    state_d  = c_ST_FAULT;
                    fault_d  = 1'b1;
                    w_bubble = 1'b1;
                end else if (branch_taken_i && w_tgt_misaligned) begin
                    state_d  = c_ST_FAULT;
                    fault_d  = 1'b1;
                    w_bubble = 1'b1;
                end else if (branch_taken_i) begin
                    // Aligned but out-of-range targets are loaded; the range
                    // check faults on the next edge.
                    pc_d     = branch_target_i;
                    w_bubble = 1'b1;
                end else if (freeze_i) begin
                    w_bubble = flush_i;
                end else if (flush_i) begin
                    pc_d     = w_pc_plus4;
                    w_bubble = 1'b1;
                end else begin
                    instr_d = imem_data_i;
                    ifpc_d  = w_pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = w_pc_plus4;
                    count_d = count_q + 32'd1;
                end
            end
            c_ST_FAULT: begin
                // Everything is frozen; only reset leaves this state.
                valid_d = 1'b0;
            end
            default: begin
                state_d  = c_ST_FAULT;
                fault_d  = 1'b1;
                w_bubble = 1'b1;
            end
        endcase

        if (w_bubble) begin
            instr_d = NOP_WORD;
            ifpc_d  = 32'd0;
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            ifpc_q  <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc_o    = ifpc_q;
    assign if_id_valid_o = valid_q;
    assign fault_o       = fault_q;
    assign fetch_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_stage
//  Purpose  : Directed self-checking bench for instruction_fetch_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        freeze;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];

    instruction_fetch_stage #(
        .RESET_PC  (32'd0),
        .MEM_BYTES (256),
        .NOP_WORD  (32'd0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_data),
        .freeze_i        (freeze),
        .flush_i         (flush),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .if_id_instr_o   (if_id_instr),
        .if_id_pc_o      (if_id_pc),
        .if_id_valid_o   (if_id_valid),
        .fault_o         (fault),
        .fetch_count_o   (fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory
    assign imem_data = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'd0); end
        total++; if (if_id_instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, 32'd0); end
        total++; if (if_id_pc !== 32'd0) begin bad++; $display("FAIL reset_ifpc got=%h exp=%h", if_id_pc, 32'd0); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_boot_first();
        tick(); // BOOT edge
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b exp=0", if_id_valid); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL boot_addr got=%h exp=0", imem_addr); end
        tick();
        total++; if (if_id_instr !== 32'h8020_000A) begin bad++; $display("FAIL first_instr got=%h exp=8020000a", if_id_instr); end
        total++; if (if_id_pc !== 32'd4) begin bad++; $display("FAIL first_ifpc got=%h exp=4", if_id_pc); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", if_id_valid); end
        total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", fetch_count); end
        total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL first_addr got=%h exp=4", imem_addr); end
    endtask

    task automatic test_freeze();
        tick(); // capture word at 4
        total++; if (imem_addr !== 32'd8) begin bad++; $display("FAIL pre_freeze_addr got=%h exp=8", imem_addr); end
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (imem_addr !== 32'd8) begin bad++; $display("FAIL freeze_addr[%0d] got=%h exp=8", k, imem_addr); end
            total++; if (if_id_instr !== mem[1]) begin bad++; $display("FAIL freeze_instr[%0d] got=%h exp=%h", k, if_id_instr, mem[1]); end
            total++; if (if_id_pc !== 32'd8) begin bad++; $display("FAIL freeze_ifpc[%0d] got=%h exp=8", k, if_id_pc); end
            total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL freeze_valid[%0d] got=%b exp=1", k, if_id_valid); end
            total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL freeze_count[%0d] got=%0d exp=2", k, fetch_count); end
        end
        freeze = 1'b0;
    endtask

    task automatic test_freeze_flush();
        freeze = 1'b1; flush = 1'b1;
        tick();
        total++; if (imem_addr !== 32'd8) begin bad++; $display("FAIL frzfl_addr got=%h exp=8", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL frzfl_valid got=%b exp=0", if_id_valid); end
        total++; if (if_id_instr !== 32'd0) begin bad++; $display("FAIL frzfl_instr got=%h exp=0", if_id_instr); end
        total++; if (if_id_pc !== 32'd0) begin bad++; $display("FAIL frzfl_ifpc got=%h exp=0", if_id_pc); end
        freeze = 1'b0;
        tick(); // flush alone: pc advances, bubble
        total++; if (imem_addr !== 32'd12) begin bad++; $display("FAIL flush_addr got=%h exp=c", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", if_id_valid); end
        total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL flush_count got=%0d exp=2", fetch_count); end
        flush = 1'b0;
        tick();
        total++; if (if_id_instr !== mem[3]) begin bad++; $display("FAIL post_flush_instr got=%h exp=%h", if_id_instr, mem[3]); end
        total++; if (if_id_pc !== 32'd16) begin bad++; $display("FAIL post_flush_ifpc got=%h exp=10", if_id_pc); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL post_flush_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_branch();
        freeze = 1'b1; flush = 1'b1; branch_taken = 1'b1; branch_target = 32'd120;
        tick();
        total++; if (imem_addr !== 32'd120) begin bad++; $display("FAIL br_addr got=%h exp=78", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", if_id_valid); end
        freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        tick();
        total++; if (if_id_instr !== 32'h2903_4800) begin bad++; $display("FAIL br_instr got=%h exp=29034800", if_id_instr); end
        total++; if (if_id_pc !== 32'd124) begin bad++; $display("FAIL br_ifpc got=%h exp=7c", if_id_pc); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL br_valid2 got=%b exp=1", if_id_valid); end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL br_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL arst_addr got=%h exp=0", imem_addr); end
        total++; if (if_id_instr !== 32'd0) begin bad++; $display("FAIL arst_instr got=%h exp=0", if_id_instr); end
        total++; if (if_id_pc !== 32'd0) begin bad++; $display("FAIL arst_ifpc got=%h exp=0", if_id_pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", if_id_valid); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", fetch_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL arst_boot_valid got=%b exp=0", if_id_valid); end
        tick();
        total++; if (if_id_instr !== 32'h8020_000A) begin bad++; $display("FAIL arst_resume_instr got=%h exp=8020000a", if_id_instr); end
        total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL arst_resume_count got=%0d exp=1", fetch_count); end
    endtask

    task automatic test_misaligned_branch();
        branch_taken = 1'b1; branch_target = 32'h6;
        tick();
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL mis_fault got=%b exp=1", fault); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%b exp=0", if_id_valid); end
        total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL mis_addr got=%h exp=4", imem_addr); end
        branch_target = 32'd40; flush = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL mis_hold_addr[%0d] got=%h exp=4", k, imem_addr); end
            total++; if (fault !== 1'b1) begin bad++; $display("FAIL mis_hold_fault[%0d] got=%b exp=1", k, fault); end
            total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL mis_hold_count[%0d] got=%0d exp=1", k, fetch_count); end
            total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL mis_hold_valid[%0d] got=%b exp=0", k, if_id_valid); end
        end
        branch_taken = 1'b0; flush = 1'b0;
    endtask

    task automatic test_branch_oob();
        do_reset();
        tick(); // BOOT
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL oob_addr got=%h exp=200", imem_addr); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL oob_fault_early got=%b exp=0", fault); end
        branch_taken = 1'b0;
        tick();
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL oob_fault got=%b exp=1", fault); end
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL oob_addr_hold got=%h exp=200", imem_addr); end
    endtask

    task automatic test_free_run();
        do_reset();
        tick(); // BOOT
        for (int k = 0; k < 64; k++) begin
            tick();
            total++;
            if (if_id_valid !== 1'b1 || if_id_instr !== mem[k] || if_id_pc !== 32'((k + 1) * 4)
                || fetch_count !== 32'(k + 1) || fault !== 1'b0) begin
                bad++;
                $display("FAIL run[%0d] got v=%b i=%h p=%h c=%0d f=%b exp v=1 i=%h p=%h c=%0d f=0",
                         k, if_id_valid, if_id_instr, if_id_pc, fetch_count, fault,
                         mem[k], 32'((k + 1) * 4), k + 1);
            end
        end
        total++; if (if_id_instr !== 32'hC03F_003F) begin bad++; $display("FAIL run_last_instr got=%h exp=c03f003f", if_id_instr); end
        total++; if (imem_addr !== 32'd256) begin bad++; $display("FAIL run_end_addr got=%h exp=100", imem_addr); end
        tick();
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL run_fault got=%b exp=1", fault); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL run_fault_valid got=%b exp=0", if_id_valid); end
        total++; if (fetch_count !== 32'd64) begin bad++; $display("FAIL run_fault_count got=%0d exp=64", fetch_count); end
        total++; if (imem_addr !== 32'd256) begin bad++; $display("FAIL run_fault_addr got=%h exp=100", imem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 + 32'(i) * 32'h0001_0001;
        mem[0]  = 32'h8020_000A;
        mem[30] = 32'h2903_4800;
        rst_n = 1'b0;
        freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;

        test_reset();
        test_boot_first();
        test_freeze();
        test_freeze_flush();
        test_branch();
        test_async_reset();
        test_misaligned_branch();
        test_branch_oob();
        test_free_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
